gpio_bank: RTL and testbench

Parametrised Wishbone GPIO port with 1–32 bidirectional pins. It has per-pin output enables, two-flop input synchronisers, and an optional rising-edge interrupt unit. It sits on the uncore Wishbone bus alongside the other peripherals and drives an open pad interface (`gpio_o`, `gpio_oe_o`, `gpio_i`) plus an interrupt line.

---
 rtl/gpio_bank.sv | 90 +++++++++
 tb/tb_gpio_bank.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// gpio_bank: Wishbone GPIO port with per-pin output enables and two-flop input synchronisers.
// Define GPIO_BANK_INTR_EN to build the rising-edge interrupt unit (IE/IP registers, irq_o).
module gpio_bank #(
  parameter int N = 8
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [1:0]   wb_adr_i,
  input  logic [31:0]  wb_dat_i,
  output logic [31:0]  wb_dat_o,
  input  logic         wb_we_i,
  input  logic [3:0]   wb_sel_i,
  input  logic         wb_stb_i,
  output logic         wb_ack_o,
  input  logic [N-1:0] gpio_i,
  output logic [N-1:0] gpio_o,
  output logic [N-1:0] gpio_oe_o,
  output logic         irq_o
);
  logic [N-1:0] out_q, out_d, dir_q, dir_d, s1_q, s2_q, din;
  logic [31:0]  dat_q, dat_d, m, rd;
  logic         ack_q, ack_d, acc, wr;
  logic         unused_bits;

  function automatic logic [N-1:0] merge(input logic [N-1:0] o, input logic [31:0] d, input logic [31:0] k);
    logic [31:0] w;
    w = (32'(o) & ~k) | (d & k);
    return w[N-1:0];
  endfunction

  assign m = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign acc = wb_stb_i & ~ack_q;
  assign wr = acc & wb_we_i;
  assign din = (out_q & dir_q) | (s2_q & ~dir_q);
  assign unused_bits = ^{wb_dat_i, m};
  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign gpio_o = out_q;
  assign gpio_oe_o = dir_q;

`ifdef GPIO_BANK_INTR_EN
  logic [N-1:0] prev_q, ie_q, ie_d, ip_q, ip_d, w1c;
  assign w1c = (wr && wb_adr_i == 2'd3) ? merge('0, wb_dat_i, m) : '0;
  assign rd = wb_adr_i == 2'd0 ? 32'(din) : wb_adr_i == 2'd1 ? 32'(dir_q) :
              wb_adr_i == 2'd2 ? 32'(ie_q) : 32'(ip_q);
  always_comb begin
    ie_d = (wr && wb_adr_i == 2'd2) ? merge(ie_q, wb_dat_i, m) : ie_q;
    // a fresh edge beats a simultaneous clear
    ip_d = (ip_q & ~w1c) | (s2_q & ~prev_q & ie_q);
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      prev_q <= '0;
      ie_q   <= '0;
      ip_q   <= '0;
    end else begin
      prev_q <= s2_q;
      ie_q   <= ie_d;
      ip_q   <= ip_d;
    end
  assign irq_o = |(ip_q & ie_q);
`else
  assign rd = wb_adr_i == 2'd0 ? 32'(din) : wb_adr_i == 2'd1 ? 32'(dir_q) : 32'd0;
  assign irq_o = 1'b0;
`endif

  always_comb begin
    out_d = (wr && wb_adr_i == 2'd0) ? merge(out_q, wb_dat_i, m) : out_q;
    dir_d = (wr && wb_adr_i == 2'd1) ? merge(dir_q, wb_dat_i, m) : dir_q;
    dat_d = acc ? rd : dat_q;
    ack_d = acc;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      out_q <= '0;
      dir_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      dat_q <= '0;
      ack_q <= 1'b0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
      s1_q  <= gpio_i;
      s2_q  <= s1_q;
      dat_q <= dat_d;
      ack_q <= ack_d;
    end
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed plus randomized checks of gpio_bank at N=8 and N=32.
module tb_gpio_bank;
  logic        clk = 0, rst = 1, we = 0, stb8 = 0, stb32 = 0;
  logic [1:0]  adr = 0;
  logic [31:0] dat = 0, rd8, rd32, gpi32 = 0, go32, oe32;
  logic [3:0]  sel = 0;
  logic [7:0]  gpi8 = 0, go8, oe8;
  logic        ack8, ack32, irq8, irq32;
  int          checks = 0, errors = 0;

  gpio_bank #(.N(8)) u8 (.wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(rd8),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb8), .wb_ack_o(ack8), .gpio_i(gpi8), .gpio_o(go8),
    .gpio_oe_o(oe8), .irq_o(irq8));
  gpio_bank #(.N(32)) u32 (.wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(rd32),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb32), .wb_ack_o(ack32), .gpio_i(gpi32), .gpio_o(go32),
    .gpio_oe_o(oe32), .irq_o(irq32));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // called at a negedge with the bus idle; returns at a negedge with the bus idle again
  task automatic acc(input bit big, input bit w, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r);
    adr = a; dat = d; we = w; sel = s;
    if (big) stb32 = 1; else stb8 = 1;
    @(negedge clk);
    chk("ack", big ? 32'(ack32) : 32'(ack8), 1);
    r = big ? rd32 : rd8;
    stb8 = 0; stb32 = 0; we = 0;
    @(negedge clk);
  endtask

  task automatic wr(input bit big, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    acc(big, 1, a, d, s, r);
  endtask

  task automatic rdchk(input bit big, input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    acc(big, 0, a, 0, 4'hF, r);
    chk(tag, r, exp);
  endtask

  initial begin
    logic [7:0] m_out, m_dir, m_gpi, m_ie, m_ip, nv, k;
    logic [31:0] v [4];
    @(negedge clk);
    chk("rst_go", 32'(go8), 0);
    chk("rst_oe", 32'(oe8), 0);
    chk("rst_ack", 32'(ack8), 0);
    chk("rst_dat", rd8, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    wr(0, 2'd1, 32'hFFFF_FFFF, 4'hF);
    chk("drive_oe", 32'(oe8), 32'hFF);
    rdchk(0, 2'd1, 32'hFF, "dir_upper_zero");
    wr(0, 2'd0, 32'hA5, 4'hF);
    chk("drive_go", 32'(go8), 32'hA5);
    rdchk(0, 2'd0, 32'hA5, "drive_rd");

    wr(0, 2'd1, 32'h0F, 4'hF);
    wr(0, 2'd0, 32'h03, 4'hF);
    gpi8 = 8'hF0;
    rdchk(0, 2'd0, 32'h03, "sync_early");
    rdchk(0, 2'd0, 32'hF3, "sync_late");

    m_out = 8'h03; m_dir = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      v[0] = $urandom; v[1] = $urandom; k = 8'($urandom_range(0, 15));
      wr(0, 2'd1, v[0], k[3:0]);
      m_dir = (m_dir & ~lanes(k[3:0])) | (v[0][7:0] & lanes(k[3:0]));
      wr(0, 2'd0, v[1], 4'hF);
      m_out = v[1][7:0];
      m_gpi = 8'($urandom); gpi8 = m_gpi;
      repeat (3) @(negedge clk);
      chk("rnd_oe", 32'(oe8), 32'(m_dir));
      chk("rnd_go", 32'(go8), 32'(m_out));
      rdchk(0, 2'd0, 32'((m_out & m_dir) | (m_gpi & ~m_dir)), "rnd_data");
    end

    wr(1, 2'd1, 32'hFFFF_FFFF, 4'hF);
    wr(1, 2'd0, 32'hFFFF_FFFF, 4'b0100);
    rdchk(1, 2'd0, 32'h00FF_0000, "lane2");
    v[0] = 32'h1111_1111; v[1] = 32'h2222_2222; v[2] = 32'h3333_3333; v[3] = 32'h4444_4444;
    adr = 0; we = 1; sel = 4'hF; stb32 = 1;
    for (int i = 0; i < 4; i++) begin
      dat = v[i];
      @(negedge clk);
      chk("held_ack", 32'(ack32), 32'(i % 2 == 0));
    end
    stb32 = 0; we = 0;
    @(negedge clk);
    chk("held_once", go32, v[2]);

    gpi8 = 0;
    repeat (4) @(negedge clk);
`ifdef GPIO_BANK_INTR_EN
    wr(0, 2'd2, 32'h01, 4'hF);
    gpi8 = 8'h01;
    repeat (2) @(negedge clk);
    chk("irq_pre", 32'(irq8), 0);
    @(negedge clk);
    chk("irq_e2", 32'(irq8), 1);
    rdchk(0, 2'd3, 32'h01, "ip_set");
    wr(0, 2'd3, 32'h01, 4'hF);
    chk("irq_clr", 32'(irq8), 0);
    rdchk(0, 2'd3, 32'h00, "ip_clr");
    gpi8 = 0;
    repeat (4) @(negedge clk);
    gpi8 = 8'h01;
    repeat (2) @(negedge clk);
    wr(0, 2'd3, 32'h01, 4'hF);
    rdchk(0, 2'd3, 32'h01, "ip_set_wins");
    chk("irq_set_wins", 32'(irq8), 1);
    wr(0, 2'd3, 32'hFF, 4'hF);
    m_gpi = gpi8; m_ip = 0; m_ie = 8'($urandom);
    wr(0, 2'd2, 32'(m_ie), 4'hF);
    for (int i = 0; i < 10; i++) begin
      nv = 8'($urandom);
      m_ip |= nv & ~m_gpi & m_ie;
      m_gpi = nv; gpi8 = nv;
      repeat (4) @(negedge clk);
      chk("rnd_irq", 32'(irq8), 32'(|(m_ip & m_ie)));
      rdchk(0, 2'd3, 32'(m_ip), "rnd_ip");
    end
    wr(0, 2'd2, 32'h00, 4'hF);
    chk("ie_off_irq", 32'(irq8), 0);
    rdchk(0, 2'd3, 32'(m_ip), "ie_off_ip_kept");
`else
    wr(0, 2'd2, 32'hFF, 4'hF);
    wr(0, 2'd3, 32'hFF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      gpi8 = ~gpi8;
      repeat (3) @(negedge clk);
      chk("noint_irq", 32'(irq8), 0);
    end
    rdchk(0, 2'd2, 0, "noint_ie");
    rdchk(0, 2'd3, 0, "noint_ip");
`endif

    gpi8 = 0;
    wr(0, 2'd0, 32'h5A, 4'hF);
    adr = 0; we = 1; dat = 32'hC3; sel = 4'hF; stb8 = 1;
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_ack", 32'(ack8), 0);
    chk("arst_dat", rd8, 0);
    chk("arst_go", 32'(go8), 0);
    chk("arst_oe", 32'(oe8), 0);
    chk("arst_irq", 32'(irq8), 0);
    @(negedge clk);
    stb8 = 0; we = 0;
    rst = 0;
    @(negedge clk);
    for (int a = 0; a < 4; a++) rdchk(0, 2'(a), 0, "arst_reg");
    chk("arst_go_after", 32'(go8), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
